// File: rtl/sample_scheduler.sv
// Sample-rate scheduler: a reload down-counter paces sample requests to the SPI master
// over val/rdy, with burst or continuous runs, stop/drain handling and a sticky overrun flag.
module sample_scheduler #(
    parameter int nbits = 32,
    parameter int cbits = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [nbits-1:0] cfg_period_msg,
    input  logic             cfg_period_val,
    output logic             cfg_period_rdy,
    input  logic [cbits-1:0] cfg_count_msg,
    input  logic             cfg_count_val,
    output logic             cfg_count_rdy,
    input  logic             start_val,
    output logic             start_rdy,
    input  logic             stop,
    output logic [cbits-1:0] req_msg,
    output logic             req_val,
    input  logic             req_rdy,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    input  logic             overrun_clr
);

    // state | meaning
    // IDLE  | waiting for config / start; cfg and start ready
    // RUN   | counter pacing ticks, each tick issues or drops a request
    // DRAIN | no more ticks; waiting for the last outstanding handshake
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [nbits-1:0] r_period;
    logic [cbits-1:0] r_count;
    logic [nbits-1:0] r_counter;
    logic [cbits-1:0] r_index;
    logic [cbits-1:0] r_issued;
    logic [cbits-1:0] r_req_msg;
    logic             r_req_val;
    logic             r_done;
    logic             r_overrun;
    logic             r_rdy;

    logic             w_hs;
    logic             w_outstanding;
    logic             w_tick;
    logic             w_start;
    logic             w_issue;
    logic             w_drop;
    logic             w_done;
    logic [cbits-1:0] w_issued_inc;

    assign w_hs          = r_req_val && req_rdy;
    assign w_outstanding = r_req_val && !req_rdy;
    assign w_tick        = (r_counter == '0);
    assign w_start       = start_val && r_rdy;
    assign w_issued_inc  = r_issued + cbits'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_drop      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (stop) begin
                    if (w_outstanding) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done      = 1'b1;
                    end
                end else if (w_tick) begin
                    if (w_outstanding) begin
                        w_drop = 1'b1;
                    end else begin
                        w_issue = 1'b1;
                        // Count of zero means continuous; issued wraps there and must not end the run.
                        if ((r_count != '0) && (w_issued_inc == r_count)) w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!w_outstanding) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_period  <= '0;
            r_count   <= '0;
            r_counter <= '0;
            r_index   <= '0;
            r_issued  <= '0;
            r_req_msg <= '0;
            r_req_val <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_rdy     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done;
            // Ready is registered so it only rises on the first edge out of reset.
            r_rdy   <= (w_state_nxt == S_IDLE);

            if (cfg_period_val && r_rdy) r_period <= cfg_period_msg;
            if (cfg_count_val && r_rdy)  r_count  <= cfg_count_msg;

            if (w_start) begin
                r_counter <= r_period;
                r_index   <= '0;
                r_issued  <= '0;
            end else if (r_state == S_RUN) begin
                r_counter <= w_tick ? r_period : (r_counter - nbits'(1));
            end

            if (w_issue) begin
                r_req_val <= 1'b1;
                r_req_msg <= r_index;
                r_index   <= r_index + cbits'(1);
                r_issued  <= w_issued_inc;
            end else if (w_hs) begin
                r_req_val <= 1'b0;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign cfg_period_rdy = r_rdy;
    assign cfg_count_rdy  = r_rdy;
    assign start_rdy      = r_rdy;
    assign req_msg        = r_req_msg;
    assign req_val        = r_req_val;
    assign busy           = (r_state != S_IDLE);
    assign done           = r_done;
    assign overrun        = r_overrun;

endmodule

// File: tb/tb_sample_scheduler.sv
// Directed bench for sample_scheduler: cycle-exact request timing, backpressure,
// wrap/stop, config lockout, async reset and stop-during-tick drain.
module tb_sample_scheduler;

    localparam int NB = 32;
    localparam int CB = 4;

    logic          clk;
    logic          reset;
    logic [NB-1:0] cfg_period_msg;
    logic          cfg_period_val;
    logic          cfg_period_rdy;
    logic [CB-1:0] cfg_count_msg;
    logic          cfg_count_val;
    logic          cfg_count_rdy;
    logic          start_val;
    logic          start_rdy;
    logic          stop;
    logic [CB-1:0] req_msg;
    logic          req_val;
    logic          req_rdy;
    logic          busy;
    logic          done;
    logic          overrun;
    logic          overrun_clr;

    int n_checks = 0;
    int n_fail   = 0;

    sample_scheduler #(.nbits(NB), .cbits(CB)) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_period_msg (cfg_period_msg),
        .cfg_period_val (cfg_period_val),
        .cfg_period_rdy (cfg_period_rdy),
        .cfg_count_msg  (cfg_count_msg),
        .cfg_count_val  (cfg_count_val),
        .cfg_count_rdy  (cfg_count_rdy),
        .start_val      (start_val),
        .start_rdy      (start_rdy),
        .stop           (stop),
        .req_msg        (req_msg),
        .req_val        (req_val),
        .req_rdy        (req_rdy),
        .busy           (busy),
        .done           (done),
        .overrun        (overrun),
        .overrun_clr    (overrun_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_period(input logic [NB-1:0] p);
        cfg_period_msg = p;
        cfg_period_val = 1'b1;
        tick();
        cfg_period_val = 1'b0;
    endtask

    task automatic cfg_count(input logic [CB-1:0] n);
        cfg_count_msg = n;
        cfg_count_val = 1'b1;
        tick();
        cfg_count_val = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        if ({req_val, busy, done, overrun, start_rdy, cfg_period_rdy, cfg_count_rdy} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0000000", {req_val, busy, done, overrun, start_rdy, cfg_period_rdy, cfg_count_rdy});
        end
        n_checks++;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        if (start_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rdy_before_edge: got %b want 0", start_rdy);
        end
        n_checks++;
        tick();
        if ({start_rdy, cfg_period_rdy, cfg_count_rdy, busy} !== 4'b1110) begin
            n_fail++;
            $display("FAIL reset_rdy_after_edge: got %b want 1110", {start_rdy, cfg_period_rdy, cfg_count_rdy, busy});
        end
        n_checks++;
    endtask

    task automatic test_burst();
        logic          exp_v;
        logic [CB-1:0] exp_m;
        req_rdy = 1'b1;
        cfg_period(3);
        cfg_count(4);
        start_val = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) start_val = 1'b0;
            exp_v = (k == 5 || k == 9 || k == 13 || k == 17);
            if (req_val !== exp_v) begin
                n_fail++;
                $display("FAIL burst_req_val T%0d: got %b want %b", k, req_val, exp_v);
            end
            n_checks++;
            if (exp_v) begin
                exp_m = CB'((k - 5) / 4);
                if (req_msg !== exp_m) begin
                    n_fail++;
                    $display("FAIL burst_req_msg T%0d: got %0d want %0d", k, req_msg, exp_m);
                end
                n_checks++;
            end
            if (done !== (k == 18)) begin
                n_fail++;
                $display("FAIL burst_done T%0d: got %b want %b", k, done, (k == 18));
            end
            n_checks++;
            if (busy !== (k <= 17)) begin
                n_fail++;
                $display("FAIL burst_busy T%0d: got %b want %b", k, busy, (k <= 17));
            end
            n_checks++;
        end
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_overrun: got %b want 0", overrun);
        end
        n_checks++;
    endtask

    task automatic test_backpressure();
        logic          exp_v;
        logic [CB-1:0] exp_m;
        req_rdy = 1'b0;
        cfg_period(1);
        cfg_count(3);
        start_val = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 1) start_val = 1'b0;
            if (k == 9) req_rdy = 1'b1;
            exp_v = (k >= 3 && k <= 9) || k == 11 || k == 13;
            exp_m = (k <= 9) ? CB'(0) : (k == 11) ? CB'(1) : CB'(2);
            if (req_val !== exp_v) begin
                n_fail++;
                $display("FAIL bp_req_val T%0d: got %b want %b", k, req_val, exp_v);
            end
            n_checks++;
            if (exp_v && req_msg !== exp_m) begin
                n_fail++;
                $display("FAIL bp_req_msg T%0d: got %0d want %0d", k, req_msg, exp_m);
            end
            if (exp_v) n_checks++;
            if (overrun !== (k >= 5)) begin
                n_fail++;
                $display("FAIL bp_overrun T%0d: got %b want %b", k, overrun, (k >= 5));
            end
            n_checks++;
            if (done !== (k == 14)) begin
                n_fail++;
                $display("FAIL bp_done T%0d: got %b want %b", k, done, (k == 14));
            end
            n_checks++;
        end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clr: got %b want 0", overrun);
        end
        n_checks++;
    endtask

    task automatic test_wrap_stop();
        logic [CB-1:0] exp_m;
        req_rdy = 1'b1;
        cfg_period(0);
        cfg_count(0);
        start_val = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 1) start_val = 1'b0;
            if (req_val !== (k >= 2)) begin
                n_fail++;
                $display("FAIL wrap_req_val T%0d: got %b want %b", k, req_val, (k >= 2));
            end
            n_checks++;
            if (k >= 2) begin
                exp_m = CB'((k - 2) % 16);
                if (req_msg !== exp_m) begin
                    n_fail++;
                    $display("FAIL wrap_req_msg T%0d: got %0d want %0d", k, req_msg, exp_m);
                end
                n_checks++;
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        if ({done, req_val, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL wrap_stop_end: done/req_val/busy got %b want 100", {done, req_val, busy});
        end
        n_checks++;
        tick();
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_done_pulse: got %b want 0", done);
        end
        n_checks++;
    endtask

    task automatic test_cfg_locked();
        logic exp_v;
        req_rdy = 1'b1;
        cfg_period(2);
        start_val = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) begin
                start_val      = 1'b0;
                cfg_period_msg = 7;
                cfg_period_val = 1'b1;
            end
            if ({cfg_period_rdy, cfg_count_rdy, start_rdy} !== 3'b000) begin
                n_fail++;
                $display("FAIL lock_rdy T%0d: got %b want 000", k, {cfg_period_rdy, cfg_count_rdy, start_rdy});
            end
            n_checks++;
            exp_v = (k == 4 || k == 7);
            if (req_val !== exp_v) begin
                n_fail++;
                $display("FAIL lock_req_val T%0d: got %b want %b", k, req_val, exp_v);
            end
            n_checks++;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        if ({done, busy, cfg_period_rdy} !== 3'b101) begin
            n_fail++;
            $display("FAIL lock_stop: done/busy/rdy got %b want 101", {done, busy, cfg_period_rdy});
        end
        n_checks++;
        tick();
        cfg_period_val = 1'b0;
        start_val      = 1'b1;
        for (int j = 1; j <= 18; j++) begin
            tick();
            if (j == 1) start_val = 1'b0;
            exp_v = (j == 9 || j == 17);
            if (req_val !== exp_v) begin
                n_fail++;
                $display("FAIL p7_req_val T%0d: got %b want %b", j, req_val, exp_v);
            end
            n_checks++;
            if (exp_v && req_msg !== ((j == 9) ? CB'(0) : CB'(1))) begin
                n_fail++;
                $display("FAIL p7_req_msg T%0d: got %0d want %0d", j, req_msg, (j == 9) ? 0 : 1);
            end
            if (exp_v) n_checks++;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL p7_done: got %b want 1", done);
        end
        n_checks++;
    endtask

    task automatic test_stop_drain();
        req_rdy = 1'b0;
        cfg_period(2);
        cfg_count(0);
        start_val = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 1)  start_val   = 1'b0;
            if (k == 6)  overrun_clr = 1'b1;
            if (k == 8)  overrun_clr = 1'b0;
            if (k == 9)  stop        = 1'b1;
            if (k == 10) stop        = 1'b0;
            if (k == 12) req_rdy     = 1'b1;
            if (req_val !== (k >= 4 && k <= 12)) begin
                n_fail++;
                $display("FAIL drain_req_val T%0d: got %b want %b", k, req_val, (k >= 4 && k <= 12));
            end
            n_checks++;
            if (req_val && req_msg !== CB'(0)) begin
                n_fail++;
                $display("FAIL drain_req_msg T%0d: got %0d want 0", k, req_msg);
            end
            if (req_val) n_checks++;
            if (overrun !== (k == 7)) begin
                n_fail++;
                $display("FAIL drain_overrun T%0d: got %b want %b", k, overrun, (k == 7));
            end
            n_checks++;
            if (busy !== (k <= 12)) begin
                n_fail++;
                $display("FAIL drain_busy T%0d: got %b want %b", k, busy, (k <= 12));
            end
            n_checks++;
            if (done !== (k == 13)) begin
                n_fail++;
                $display("FAIL drain_done T%0d: got %b want %b", k, done, (k == 13));
            end
            n_checks++;
        end
    endtask

    task automatic test_async_reset();
        req_rdy = 1'b0;
        cfg_period(0);
        cfg_count(0);
        start_val = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) start_val = 1'b0;
        end
        if ({req_val, busy, overrun} !== 3'b111) begin
            n_fail++;
            $display("FAIL arst_pre: req_val/busy/overrun got %b want 111", {req_val, busy, overrun});
        end
        n_checks++;
        #4 reset = 1'b0;
        #1;
        if ({req_val, busy, overrun, done, start_rdy} !== 5'b0) begin
            n_fail++;
            $display("FAIL arst_immediate: got %b want 00000", {req_val, busy, overrun, done, start_rdy});
        end
        n_checks++;
        #2 reset = 1'b1;
        tick();
        if ({busy, start_rdy, cfg_period_rdy} !== 3'b011) begin
            n_fail++;
            $display("FAIL arst_release: busy/start_rdy/cfg_rdy got %b want 011", {busy, start_rdy, cfg_period_rdy});
        end
        n_checks++;
        req_rdy   = 1'b1;
        start_val = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) start_val = 1'b0;
            if (req_val !== (k >= 2)) begin
                n_fail++;
                $display("FAIL arst_p0_req_val T%0d: got %b want %b", k, req_val, (k >= 2));
            end
            n_checks++;
            if (k == 2 || k == 3) begin
                if (req_msg !== CB'(k - 2)) begin
                    n_fail++;
                    $display("FAIL arst_p0_req_msg T%0d: got %0d want %0d", k, req_msg, k - 2);
                end
                n_checks++;
            end
        end
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_n0_busy: got %b want 1", busy);
        end
        n_checks++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        if ({done, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL arst_stop: done/busy got %b want 10", {done, busy});
        end
        n_checks++;
    endtask

    initial begin
        reset          = 1'b0;
        cfg_period_msg = '0;
        cfg_period_val = 1'b0;
        cfg_count_msg  = '0;
        cfg_count_val  = 1'b0;
        start_val      = 1'b0;
        stop           = 1'b0;
        req_rdy        = 1'b0;
        overrun_clr    = 1'b0;
        test_reset();
        test_burst();
        test_backpressure();
        test_wrap_stop();
        test_cfg_locked();
        test_stop_drain();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
